// File: rtl/addsub_arbiter.sv
// ---------------------------------------------------------------------------
// addsub_arbiter
//
// Purpose:
//   Two requesters share one external WIDTH-bit adder/subtractor.
//   Requester operations are accepted over valid/ready, and the operands are
//   registered onto the shared unit (au_*). Its result is captured one cycle
//   later and then returned on the requester's own response channel. Only
//   one transaction is in flight at a time, and ties are resolved
//   round-robin.
//
// Handshake semantics (all channels):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   The source holds valid and payload stable until it sees ready. The
//   source may drop valid before ready; no transfer happens in that case.
//   req*_ready is combinational from req*_valid in IDLE.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   reqN_valid/ready           requester N operation channel
//   reqN_a, reqN_b, reqN_op    operands; op 0 = A+B, 1 = A-B
//   rspN_valid/ready           requester N response channel
//   rspN_s/carry/overflow      result, raw carry-out, signed overflow
//   au_a, au_b, au_op          registered drive to the shared unit
//   au_s/carry/overflow        shared unit outputs (combinational from au_*)
//   cnt0, cnt1, ovf_seen       statistics (only with ADDSUB_ARB_STATS_EN)
//   dbg_state                  current FSM state (0 IDLE, 1 EXEC, 2 RESP)
//
// Optional feature macro: ADDSUB_ARB_STATS_EN
//   When this macro is defined, the block adds per-requester completion
//   counters and a sticky overflow flag.
// ---------------------------------------------------------------------------
module addsub_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   // requester 0
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_op,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_s,
   output logic             rsp0_carry,
   output logic             rsp0_overflow,
   // requester 1
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_op,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_s,
   output logic             rsp1_carry,
   output logic             rsp1_overflow,
   // shared add/sub unit
   output logic [WIDTH-1:0] au_a,
   output logic [WIDTH-1:0] au_b,
   output logic             au_op,
   input  logic [WIDTH-1:0] au_s,
   input  logic             au_carry,
   input  logic             au_overflow,
`ifdef ADDSUB_ARB_STATS_EN
   output logic [15:0]      cnt0,
   output logic [15:0]      cnt1,
   output logic             ovf_seen,
`endif
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t state;
   logic   last_grant;   // requester served most recently
   logic   cur_grant;    // requester owning the in-flight transaction

   // ------------------------------------------------------------------------
   // Grant selection (meaningful only in IDLE)
   // ------------------------------------------------------------------------
   logic gnt_any;
   logic gnt_sel;

   always_comb begin
      gnt_any = req0_valid | req1_valid;
      gnt_sel = 1'b0;
      if (req0_valid && req1_valid) begin
         // Tie: the requester that did not go last wins.
         gnt_sel = ~last_grant;
      end else if (req1_valid) begin
         gnt_sel = 1'b1;
      end
   end

   // Ready is gated by rst_n so nothing appears accepted while in reset.
   assign req0_ready = rst_n && (state == S_IDLE) && req0_valid && !gnt_sel;
   assign req1_ready = rst_n && (state == S_IDLE) && req1_valid &&  gnt_sel;

   logic accept;
   assign accept = (req0_valid && req0_ready) || (req1_valid && req1_ready);

   // Response handshake for the in-flight transaction.
   logic rsp_done;
   assign rsp_done = (state == S_RESP) &&
                     (cur_grant ? (rsp1_valid && rsp1_ready)
                                : (rsp0_valid && rsp0_ready));

   // ------------------------------------------------------------------------
   // Controller FSM with registered datapath outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         last_grant    <= 1'b1;
         cur_grant     <= 1'b0;
         au_a          <= '0;
         au_b          <= '0;
         au_op         <= 1'b0;
         rsp0_valid    <= 1'b0;
         rsp0_s        <= '0;
         rsp0_carry    <= 1'b0;
         rsp0_overflow <= 1'b0;
         rsp1_valid    <= 1'b0;
         rsp1_s        <= '0;
         rsp1_carry    <= 1'b0;
         rsp1_overflow <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               // au_* only ever change here, so the shared unit sees stable
               // operands for the whole EXEC cycle and beyond.
               if (accept) begin
                  cur_grant <= gnt_sel;
                  au_a      <= gnt_sel ? req1_a  : req0_a;
                  au_b      <= gnt_sel ? req1_b  : req0_b;
                  au_op     <= gnt_sel ? req1_op : req0_op;
                  state     <= S_EXEC;
               end
            end

            S_EXEC: begin
               // The shared unit is combinational, so its result is settled
               // one cycle after the operands were registered.
               if (cur_grant) begin
                  rsp1_s        <= au_s;
                  rsp1_carry    <= au_carry;
                  rsp1_overflow <= au_overflow;
                  rsp1_valid    <= 1'b1;
               end else begin
                  rsp0_s        <= au_s;
                  rsp0_carry    <= au_carry;
                  rsp0_overflow <= au_overflow;
                  rsp0_valid    <= 1'b1;
               end
               state <= S_RESP;
            end

            S_RESP: begin
               // Result registers stay untouched until the consumer takes it.
               if (rsp_done) begin
                  if (cur_grant) rsp1_valid <= 1'b0;
                  else           rsp0_valid <= 1'b0;
                  last_grant <= cur_grant;
                  state      <= S_IDLE;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign dbg_state = state;

`ifdef ADDSUB_ARB_STATS_EN
   // ------------------------------------------------------------------------
   // Statistics: completed responses per requester, sticky overflow flag
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0     <= 16'd0;
         cnt1     <= 16'd0;
         ovf_seen <= 1'b0;
      end else begin
         if (rsp_done && !cur_grant) cnt0 <= cnt0 + 16'd1;  // wraps naturally
         if (rsp_done &&  cur_grant) cnt1 <= cnt1 + 16'd1;
         if ((state == S_EXEC) && au_overflow) ovf_seen <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// ---------------------------------------------------------------------------
// tb_addsub_arbiter
//
// Directed bench for addsub_arbiter. A small behavioural add/sub unit stands
// in for the external shared datapath. Expected results are hand-computed
// constants.
// ---------------------------------------------------------------------------
module tb_addsub_arbiter;

   localparam int WIDTH = 8;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic             req0_valid, req0_ready, req0_op;
   logic [WIDTH-1:0] req0_a, req0_b;
   logic             rsp0_valid, rsp0_ready, rsp0_carry, rsp0_overflow;
   logic [WIDTH-1:0] rsp0_s;
   logic             req1_valid, req1_ready, req1_op;
   logic [WIDTH-1:0] req1_a, req1_b;
   logic             rsp1_valid, rsp1_ready, rsp1_carry, rsp1_overflow;
   logic [WIDTH-1:0] rsp1_s;
   logic [WIDTH-1:0] au_a, au_b, au_s;
   logic             au_op, au_carry, au_overflow;
   logic [1:0]       dbg_state;
`ifdef ADDSUB_ARB_STATS_EN
   logic [15:0]      cnt0, cnt1;
   logic             ovf_seen;
`endif

   addsub_arbiter #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp0_s(rsp0_s), .rsp0_carry(rsp0_carry), .rsp0_overflow(rsp0_overflow),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp1_s(rsp1_s), .rsp1_carry(rsp1_carry), .rsp1_overflow(rsp1_overflow),
      .au_a(au_a), .au_b(au_b), .au_op(au_op),
      .au_s(au_s), .au_carry(au_carry), .au_overflow(au_overflow),
`ifdef ADDSUB_ARB_STATS_EN
      .cnt0(cnt0), .cnt1(cnt1), .ovf_seen(ovf_seen),
`endif
      .dbg_state(dbg_state)
   );

   // Shared add/sub unit: subtract = A + ~B + 1, raw carry, signed overflow.
   logic [WIDTH-1:0] au_b_eff;
   always_comb begin
      au_b_eff                = au_op ? ~au_b : au_b;
      {au_carry, au_s}        = {1'b0, au_a} + {1'b0, au_b_eff} + {{WIDTH{1'b0}}, au_op};
      au_overflow             = (au_a[WIDTH-1] == au_b_eff[WIDTH-1]) &&
                                (au_s[WIDTH-1] != au_a[WIDTH-1]);
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then sample 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete transaction from requester `which` with rsp_ready high.
   task automatic run_op(input bit which, input logic [7:0] a, input logic [7:0] b,
                         input bit op, input logic [7:0] es, input bit ec, input bit eo);
      if (!which) begin
         req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; rsp0_ready = 1'b1;
      end else begin
         req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; rsp1_ready = 1'b1;
      end
      #1;
      chk("op_ready",  which ? req1_ready : req0_ready, 1);
      chk("op_other_ready", which ? req0_ready : req1_ready, 0);
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk("op_exec_state", dbg_state, 1);
      chk("op_au_a", au_a, a);
      chk("op_au_b", au_b, b);
      chk("op_au_op", au_op, op);
      chk("op_no_early_valid", which ? rsp1_valid : rsp0_valid, 0);
      step();
      chk("op_rsp_valid", which ? rsp1_valid : rsp0_valid, 1);
      chk("op_rsp_s", which ? rsp1_s : rsp0_s, es);
      chk("op_rsp_carry", which ? rsp1_carry : rsp0_carry, ec);
      chk("op_rsp_ovf", which ? rsp1_overflow : rsp0_overflow, eo);
      chk("op_other_rsp_idle", which ? rsp0_valid : rsp1_valid, 0);
      step();
      chk("op_rsp_cleared", which ? rsp1_valid : rsp0_valid, 0);
      chk("op_back_idle", dbg_state, 0);
   endtask

   initial begin
      req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_op = 1'b0; rsp0_ready = 1'b0;
      req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_op = 1'b0; rsp1_ready = 1'b0;

      // ---- reset state (valids high to show ready is forced low) ----
      step();
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      chk("rst_state", dbg_state, 0);
      chk("rst_au_a", au_a, 0);
      chk("rst_au_b", au_b, 0);
      chk("rst_au_op", au_op, 0);
      chk("rst_rsp0_valid", rsp0_valid, 0);
      chk("rst_rsp1_valid", rsp1_valid, 0);
      chk("rst_rsp0_s", rsp0_s, 0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst_n = 1'b1;
      step();

      // ---- single requester transactions ----
      run_op(1'b0, 8'h0C, 8'h0C, 1'b0, 8'h18, 1'b0, 1'b0);
      run_op(1'b1, 8'h0C, 8'h0C, 1'b1, 8'h00, 1'b1, 1'b0);
      run_op(1'b1, 8'h0D, 8'h19, 1'b1, 8'hF4, 1'b0, 1'b0);

      // ---- both valid continuously: grants alternate 0,1,0,1 ----
      req0_valid = 1'b1; req0_a = 8'h64; req0_b = 8'h32; req0_op = 1'b0; rsp0_ready = 1'b1;
      req1_valid = 1'b1; req1_a = 8'hB0; req1_b = 8'h3C; req1_op = 1'b1; rsp1_ready = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("rr_ready0", req0_ready, (k % 2 == 0) ? 16'd1 : 16'd0);
         chk("rr_ready1", req1_ready, (k % 2 == 1) ? 16'd1 : 16'd0);
         step();
         chk("rr_au_a", au_a, (k % 2 == 0) ? 16'h64 : 16'hB0);
         step();
         if (k % 2 == 0) begin
            chk("rr_rsp0_valid", rsp0_valid, 1);
            chk("rr_rsp0_s", rsp0_s, 16'h96);
            chk("rr_rsp0_carry", rsp0_carry, 0);
            chk("rr_rsp0_ovf", rsp0_overflow, 1);
         end else begin
            chk("rr_rsp1_valid", rsp1_valid, 1);
            chk("rr_rsp1_s", rsp1_s, 16'h74);
            chk("rr_rsp1_carry", rsp1_carry, 1);
            chk("rr_rsp1_ovf", rsp1_overflow, 1);
         end
         step();
         chk("rr_idle", dbg_state, 0);
      end

      // ---- response backpressure on requester 0, requester 1 waiting ----
      rsp0_ready = 1'b0;
      #1;
      chk("bp_ready0", req0_ready, 1);
      step();
      req0_valid = 1'b0;
      step();
      for (int k = 0; k < 5; k++) begin
         chk("bp_rsp0_valid", rsp0_valid, 1);
         chk("bp_rsp0_s", rsp0_s, 16'h96);
         chk("bp_req1_ready", req1_ready, 0);
         chk("bp_state", dbg_state, 2);
         step();
      end
      rsp0_ready = 1'b1;
      step();
      chk("bp_released_idle", dbg_state, 0);
      chk("bp_rsp0_cleared", rsp0_valid, 0);
      chk("bp_req1_ready_now", req1_ready, 1);

      // ---- reset during EXEC ----
      step();
      req1_valid = 1'b0;
      chk("mid_exec_state", dbg_state, 1);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_state", dbg_state, 0);
      chk("mid_rst_rsp1_valid", rsp1_valid, 0);
      chk("mid_rst_req0_ready", req0_ready, 0);
      chk("mid_rst_req1_ready", req1_ready, 0);
      chk("mid_rst_au_a", au_a, 0);
      step();
      rst_n = 1'b1;
      #1;
      chk("post_rst_tie_req0", req0_ready, 1);
      chk("post_rst_tie_req1", req1_ready, 0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      step();
      chk("post_rst_idle", dbg_state, 0);

      // ---- mixed traffic: 3 ops from req0 (one overflowing), 2 from req1 ----
      run_op(1'b0, 8'h64, 8'h32, 1'b0, 8'h96, 1'b0, 1'b1);
      run_op(1'b0, 8'h0C, 8'h0C, 1'b0, 8'h18, 1'b0, 1'b0);
      run_op(1'b1, 8'h0C, 8'h0C, 1'b1, 8'h00, 1'b1, 1'b0);
      run_op(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      run_op(1'b1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
`ifdef ADDSUB_ARB_STATS_EN
      chk("stats_cnt0", cnt0, 3);
      chk("stats_cnt1", cnt1, 2);
      chk("stats_ovf_seen", ovf_seen, 1);
      rst_n = 1'b0;
      #1;
      chk("stats_rst_cnt0", cnt0, 0);
      chk("stats_rst_cnt1", cnt1, 0);
      chk("stats_rst_ovf", ovf_seen, 0);
      step();
      rst_n = 1'b1;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
